// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 access codes,
// FSM state encodings and the access-size decode helper.
package load_store_unit_pkg;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_REQ  = 2'b01,
    LSU_DONE = 2'b10
  } lsu_state_t;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10
  } lsu_size_t;

  // Access width from funct3; unsigned codes are loads only, so a store
  // carrying one (like any other undefined code) falls back to a word.
  function automatic lsu_size_t lsu_size(input logic [2:0] funct3, input logic is_store);
    lsu_size_t s;
    case (funct3)
      FUNCT3_LB:  s = SIZE_B;
      FUNCT3_LH:  s = SIZE_H;
      FUNCT3_LBU: s = is_store ? SIZE_W : SIZE_B;
      FUNCT3_LHU: s = is_store ? SIZE_W : SIZE_H;
      default:    s = SIZE_W;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus: valid/ready request with byte strobes; read data is
// returned in the same cycle ready is asserted.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  valid;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  ready;
  logic [31:0]           rdata;

  modport master (output valid, we, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, we, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/load_store_unit_align.sv
// Lane logic for the load/store unit (lsu_align): store strobes and
// lane-replicated write data from the live request, load lane extraction
// and extension from the latched request, and misalignment detection when
// LSU_MISALIGN_TRAP_EN is defined.
module load_store_unit_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  req_funct3,
  input  logic        req_we,
  input  logic [1:0]  req_addr_lo,
  input  logic [31:0] req_wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic        misaligned,
`endif
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  lsu_size_t req_size;
  lsu_size_t ld_size;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign req_size = lsu_size(req_funct3, req_we);
  assign ld_size  = lsu_size(ld_funct3, 1'b0);

  // Store strobes and replicated write data; low address bits beyond the
  // access width are simply not used, which forces alignment.
  always_comb begin
    wstrb = 4'b1111;
    wdata = req_wdata;
    case (req_size)
      SIZE_B: begin
        wstrb = 4'b0001 << req_addr_lo;
        wdata = {4{req_wdata[7:0]}};
      end
      SIZE_H: begin
        wstrb = 4'b0011 << {req_addr_lo[1], 1'b0};
        wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        wstrb = 4'b1111;
        wdata = req_wdata;
      end
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // Misaligned when the low bits are not a multiple of the access width.
  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      SIZE_B:  misaligned = 1'b0;
      SIZE_H:  misaligned = req_addr_lo[0];
      default: misaligned = (req_addr_lo != 2'b00);
    endcase
  end
`endif

  // Pick the addressed lane of the read word and sign/zero-extend it;
  // funct3[2] marks the unsigned variants.
  always_comb begin
    case (ld_addr_lo)
      2'b00:   ld_byte = ld_rdata[7:0];
      2'b01:   ld_byte = ld_rdata[15:8];
      2'b10:   ld_byte = ld_rdata[23:16];
      default: ld_byte = ld_rdata[31:24];
    endcase
    ld_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    case (ld_size)
      SIZE_B:  ld_data = ld_funct3[2] ? {24'h000000, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SIZE_H:  ld_data = ld_funct3[2] ? {16'h0000, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one load or store from the decoder, runs a
// valid/ready transaction on the data bus, and stalls the core until the
// access completes or times out. Optional feature macro:
// LSU_MISALIGN_TRAP_EN (trap misaligned accesses instead of forcing them
// aligned; adds port o_misaligned).
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_mem_re,
  input  logic                  i_mem_we,
  input  logic [2:0]            i_funct3,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata,
  output logic                  o_stall,
  output logic                  o_bus_err,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic                  o_misaligned,
`endif
  load_store_unit_if.master     bus
);

  localparam logic [7:0] CNT_LIMIT = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_t  state;
  logic [7:0]  cnt;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic [31:0] ld_data;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        req_misaligned;
`endif

  load_store_unit_align u_align (
    .req_funct3  (i_funct3),
    .req_we      (i_mem_we),
    .req_addr_lo (i_addr[1:0]),
    .req_wdata   (i_wdata),
    .wstrb       (req_wstrb),
    .wdata       (req_wdata),
`ifdef LSU_MISALIGN_TRAP_EN
    .misaligned  (req_misaligned),
`endif
    .ld_funct3   (funct3_q),
    .ld_addr_lo  (addr_lo_q),
    .ld_rdata    (bus.rdata),
    .ld_data     (ld_data)
  );

  // Stall raised combinationally as soon as a request shows up in IDLE,
  // held through REQ and released for the single DONE cycle.
  always_comb begin
    case (state)
      LSU_IDLE: o_stall = i_mem_re | i_mem_we;
      LSU_REQ:  o_stall = 1'b1;
      LSU_DONE: o_stall = 1'b0;
      default:  o_stall = 1'b0;
    endcase
  end

  // Access FSM with registered bus outputs, load result and error pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= LSU_IDLE;
      cnt          <= 8'd0;
      funct3_q     <= 3'b000;
      addr_lo_q    <= 2'b00;
      bus.valid    <= 1'b0;
      bus.we       <= 1'b0;
      bus.addr     <= '0;
      bus.wdata    <= 32'h0000_0000;
      bus.wstrb    <= 4'b0000;
      o_rdata      <= 32'h0000_0000;
      o_bus_err    <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      o_misaligned <= 1'b0;
`endif
    end else begin
      o_bus_err    <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      o_misaligned <= 1'b0;
`endif
      case (state)
        LSU_IDLE: begin
          if (i_mem_re | i_mem_we) begin
            // Store wins when both enables are high.
            cnt       <= 8'd0;
            funct3_q  <= i_funct3;
            addr_lo_q <= i_addr[1:0];
            bus.we    <= i_mem_we;
            bus.addr  <= {i_addr[ADDR_WIDTH-1:2], 2'b00};
            bus.wdata <= req_wdata;
            bus.wstrb <= i_mem_we ? req_wstrb : 4'b0000;
`ifdef LSU_MISALIGN_TRAP_EN
            if (req_misaligned) begin
              o_misaligned <= 1'b1;
              o_rdata      <= 32'h0000_0000;
              state        <= LSU_DONE;
            end else begin
              bus.valid <= 1'b1;
              state     <= LSU_REQ;
            end
`else
            bus.valid <= 1'b1;
            state     <= LSU_REQ;
`endif
          end
        end
        LSU_REQ: begin
          if (bus.ready) begin
            // Ready beats a timeout landing in the same cycle.
            bus.valid <= 1'b0;
            if (!bus.we) begin
              o_rdata <= ld_data;
            end
            state <= LSU_DONE;
          end else if (cnt == CNT_LIMIT) begin
            bus.valid <= 1'b0;
            o_rdata   <= 32'h0000_0000;
            o_bus_err <= 1'b1;
            state     <= LSU_DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        LSU_DONE: begin
          state <= LSU_IDLE;
        end
        default: begin
          bus.valid <= 1'b0;
          state     <= LSU_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: the stimulus pushes the expected bus
// request and completion for each access, and a negedge monitor pops and
// compares them when the DUT handshakes on the bus or releases the stall.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          vcycles;
  } bus_exp_t;

  typedef struct {
    logic        chk_rdata;
    logic [31:0] rdata;
    logic        err;
    int          stalls;
    logic        misal;
  } res_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_re = 1'b0;
  logic        mem_we = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        stall;
  logic        bus_err;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  bus_exp_t bus_q[$];
  res_exp_t res_q[$];

  load_store_unit_if #(.ADDR_WIDTH(32)) bus ();

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_mem_re     (mem_re),
    .i_mem_we     (mem_we),
    .i_funct3     (funct3),
    .i_addr       (addr),
    .i_wdata      (wdata),
    .o_rdata      (rdata),
    .o_stall      (stall),
    .o_bus_err    (bus_err),
`ifdef LSU_MISALIGN_TRAP_EN
    .o_misaligned (misaligned),
`endif
    .bus          (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic bus_exp_t mk_bus(input logic we, input logic [31:0] a, input logic [31:0] wd,
                                      input logic [3:0] st, input int vc);
    bus_exp_t b;
    b.we = we; b.addr = a; b.wdata = wd; b.wstrb = st; b.vcycles = vc;
    return b;
  endfunction

  function automatic res_exp_t mk_res(input logic cr, input logic [31:0] rd, input logic err,
                                      input int st, input logic mis);
    res_exp_t r;
    r.chk_rdata = cr; r.rdata = rd; r.err = err; r.stalls = st; r.misal = mis;
    return r;
  endfunction

  // Monitor state
  int          stall_run = 0;
  int          valid_run = 0;
  logic        prev_stall = 1'b0;
  logic        prev_valid = 1'b0;
  logic [31:0] held_addr, held_wdata;
  logic [3:0]  held_wstrb;
  logic        held_we;

  // Monitor: compare bus requests at handshake and results when the stall drops.
  always @(negedge clk) begin
    bus_exp_t b;
    res_exp_t r;
    if (rst) begin
      stall_run  = 0;
      valid_run  = 0;
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (stall) begin
        stall_run++;
      end else if (prev_stall) begin
        if (res_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_done: actual=completion required=none");
        end else begin
          r = res_q.pop_front();
          chk("stall_cycles", stall_run, r.stalls);
          chk("bus_err", {31'd0, bus_err}, {31'd0, r.err});
          if (r.chk_rdata) chk("rdata", rdata, r.rdata);
`ifdef LSU_MISALIGN_TRAP_EN
          chk("misaligned", {31'd0, misaligned}, {31'd0, r.misal});
`endif
        end
        stall_run = 0;
      end else begin
        stall_run = 0;
        chk("err_outside_done", {31'd0, bus_err}, 32'd0);
      end

      if (bus.valid) begin
        valid_run++;
        if (prev_valid) begin
          chk("hold_addr", bus.addr, held_addr);
          chk("hold_wdata", bus.wdata, held_wdata);
          chk("hold_wstrb", {28'd0, bus.wstrb}, {28'd0, held_wstrb});
          chk("hold_we", {31'd0, bus.we}, {31'd0, held_we});
        end
        held_addr = bus.addr; held_wdata = bus.wdata;
        held_wstrb = bus.wstrb; held_we = bus.we;
        if (bus.ready) begin
          if (bus_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_handshake: actual=handshake required=none");
          end else begin
            b = bus_q.pop_front();
            chk("bus_we", {31'd0, bus.we}, {31'd0, b.we});
            chk("bus_addr", bus.addr, b.addr);
            chk("bus_wstrb", {28'd0, bus.wstrb}, {28'd0, b.wstrb});
            if (b.we) chk("bus_wdata", bus.wdata, b.wdata);
            chk("valid_cycles", valid_run, b.vcycles);
          end
          valid_run = 0;
        end
      end else begin
        valid_run = 0;
      end
      prev_valid = bus.valid && !bus.ready;
      prev_stall = stall;
    end
  end

  // Drive one access; called at posedge+1 with the unit idle.
  task automatic access(input logic re, input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int delay,
                        input bit use_bus, input bit give_ready);
    int n;
    mem_re = re; mem_we = we; funct3 = f3; addr = a; wdata = wd; bus.rdata = rd;
    if (use_bus) begin
      n = 0;
      do begin
        @(posedge clk); #1; n++;
      end while (!bus.valid && n < 20);
      if (!bus.valid) begin
        n_checks++; n_fail++;
        $display("FAIL valid_wait: actual=no valid required=valid within 20 cycles");
      end
      repeat (delay) begin @(posedge clk); #1; end
      bus.ready = give_ready;
    end
    #1;
    n = 0;
    while (stall && n < 300) begin
      @(posedge clk); #1; n++;
      if (!use_bus) chk("no_valid", {31'd0, bus.valid}, 32'd0);
    end
    if (stall) begin
      n_checks++; n_fail++;
      $display("FAIL stall_wait: actual=stall high required=release within 300 cycles");
    end
    mem_re = 1'b0; mem_we = 1'b0; bus.ready = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    bus.ready = 1'b0;
    bus.rdata = 32'h0;
    #1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_valid", {31'd0, bus.valid}, 32'd0);
    chk("rst_we", {31'd0, bus.we}, 32'd0);
    chk("rst_addr", bus.addr, 32'h0);
    chk("rst_wdata", bus.wdata, 32'h0);
    chk("rst_wstrb", {28'd0, bus.wstrb}, 32'd0);
    chk("rst_err", {31'd0, bus_err}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // SW, ready on the first REQ cycle
    bus_q.push_back(mk_bus(1'b1, 32'h100, 32'hDEADBEEF, 4'b1111, 1));
    res_q.push_back(mk_res(1'b0, 32'h0, 1'b0, 2, 1'b0));
    access(1'b0, 1'b1, FUNCT3_SW, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1'b1, 1'b1);

    // SB top lane
    bus_q.push_back(mk_bus(1'b1, 32'h100, 32'hABABABAB, 4'b1000, 1));
    res_q.push_back(mk_res(1'b0, 32'h0, 1'b0, 2, 1'b0));
    access(1'b0, 1'b1, FUNCT3_SB, 32'h103, 32'h000000AB, 32'h0, 0, 1'b1, 1'b1);

    // SH upper half, one wait cycle
    bus_q.push_back(mk_bus(1'b1, 32'h100, 32'hCAFECAFE, 4'b1100, 2));
    res_q.push_back(mk_res(1'b0, 32'h0, 1'b0, 3, 1'b0));
    access(1'b0, 1'b1, FUNCT3_SH, 32'h102, 32'h1234CAFE, 32'h0, 1, 1'b1, 1'b1);

    // LB / LBU / LHU / LH
    bus_q.push_back(mk_bus(1'b0, 32'h100, 32'h0, 4'b0000, 1));
    res_q.push_back(mk_res(1'b1, 32'hFFFFFF80, 1'b0, 2, 1'b0));
    access(1'b1, 1'b0, FUNCT3_LB, 32'h102, 32'h0, 32'h00800000, 0, 1'b1, 1'b1);
    bus_q.push_back(mk_bus(1'b0, 32'h100, 32'h0, 4'b0000, 1));
    res_q.push_back(mk_res(1'b1, 32'h00000080, 1'b0, 2, 1'b0));
    access(1'b1, 1'b0, FUNCT3_LBU, 32'h102, 32'h0, 32'h00800000, 0, 1'b1, 1'b1);
    bus_q.push_back(mk_bus(1'b0, 32'h100, 32'h0, 4'b0000, 1));
    res_q.push_back(mk_res(1'b1, 32'h0000BEEF, 1'b0, 2, 1'b0));
    access(1'b1, 1'b0, FUNCT3_LHU, 32'h102, 32'h0, 32'hBEEF0000, 0, 1'b1, 1'b1);
    bus_q.push_back(mk_bus(1'b0, 32'h200, 32'h0, 4'b0000, 1));
    res_q.push_back(mk_res(1'b1, 32'hFFFF8001, 1'b0, 2, 1'b0));
    access(1'b1, 1'b0, FUNCT3_LH, 32'h200, 32'h0, 32'h12348001, 0, 1'b1, 1'b1);

    // LW with ready withheld 5 cycles
    bus_q.push_back(mk_bus(1'b0, 32'h300, 32'h0, 4'b0000, 6));
    res_q.push_back(mk_res(1'b1, 32'h01234567, 1'b0, 7, 1'b0));
    access(1'b1, 1'b0, FUNCT3_LW, 32'h300, 32'h0, 32'h01234567, 5, 1'b1, 1'b1);

    // LW timeout (limit 8 REQ cycles)
    res_q.push_back(mk_res(1'b1, 32'h0, 1'b1, 9, 1'b0));
    access(1'b1, 1'b0, FUNCT3_LW, 32'h304, 32'h0, 32'h55555555, 0, 1'b1, 1'b0);

    // Ready in the same cycle the counter hits its limit: no error
    bus_q.push_back(mk_bus(1'b0, 32'h308, 32'h0, 4'b0000, 8));
    res_q.push_back(mk_res(1'b1, 32'hA5A50F0F, 1'b0, 9, 1'b0));
    access(1'b1, 1'b0, FUNCT3_LW, 32'h308, 32'h0, 32'hA5A50F0F, 7, 1'b1, 1'b1);

    // re and we together: store wins
    bus_q.push_back(mk_bus(1'b1, 32'h404, 32'h11223344, 4'b1111, 1));
    res_q.push_back(mk_res(1'b0, 32'h0, 1'b0, 2, 1'b0));
    access(1'b1, 1'b1, FUNCT3_SW, 32'h404, 32'h11223344, 32'h0, 0, 1'b1, 1'b1);

    // Undefined funct3 load treated as a word
    bus_q.push_back(mk_bus(1'b0, 32'h208, 32'h0, 4'b0000, 1));
    res_q.push_back(mk_res(1'b1, 32'h0BADF00D, 1'b0, 2, 1'b0));
    access(1'b1, 1'b0, 3'b011, 32'h208, 32'h0, 32'h0BADF00D, 0, 1'b1, 1'b1);

    // Misaligned LW and LH
`ifdef LSU_MISALIGN_TRAP_EN
    res_q.push_back(mk_res(1'b1, 32'h0, 1'b0, 1, 1'b1));
    access(1'b1, 1'b0, FUNCT3_LW, 32'h101, 32'h0, 32'h87654321, 0, 1'b0, 1'b0);
    res_q.push_back(mk_res(1'b1, 32'h0, 1'b0, 1, 1'b1));
    access(1'b1, 1'b0, FUNCT3_LH, 32'h103, 32'h0, 32'hF00D0000, 0, 1'b0, 1'b0);
`else
    bus_q.push_back(mk_bus(1'b0, 32'h100, 32'h0, 4'b0000, 1));
    res_q.push_back(mk_res(1'b1, 32'h87654321, 1'b0, 2, 1'b0));
    access(1'b1, 1'b0, FUNCT3_LW, 32'h101, 32'h0, 32'h87654321, 0, 1'b1, 1'b1);
    bus_q.push_back(mk_bus(1'b0, 32'h100, 32'h0, 4'b0000, 1));
    res_q.push_back(mk_res(1'b1, 32'hFFFFF00D, 1'b0, 2, 1'b0));
    access(1'b1, 1'b0, FUNCT3_LH, 32'h103, 32'h0, 32'hF00D0000, 0, 1'b1, 1'b1);
`endif

    // Reset during REQ, then a late ready must be ignored
    mem_re = 1'b1; funct3 = FUNCT3_LW; addr = 32'h500;
    @(posedge clk); #1;
    chk("req_valid_before_rst", {31'd0, bus.valid}, 32'd1);
    rst = 1'b1; mem_re = 1'b0;
    #1;
    chk("valid_after_rst", {31'd0, bus.valid}, 32'd0);
    chk("rdata_after_rst", rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.ready = 1'b1; bus.rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    bus.ready = 1'b0;
    chk("late_ready_rdata", rdata, 32'h0);
    chk("late_ready_valid", {31'd0, bus.valid}, 32'd0);
    chk("late_ready_stall", {31'd0, stall}, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("bus_q_empty", bus_q.size(), 32'd0);
    chk("res_q_empty", res_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Responder for the data-memory control issued by the decoder (mem read/write enable, funct3 width) in the RV32I core.
- Accepts one load or store per instruction, and for stores generates byte strobes and lane-replicated write data.
- Runs a valid/ready transaction on the data bus, and sign- or zero-extends load data.
- Holds the core via o_stall until the access completes. Sits between the core datapath (ALU address, rs2 data, write-back mux) and the data-memory bus.

Parameters:
- ADDR_WIDTH, 32, byte address width on core and bus sides.
- TIMEOUT_CYCLES, 255, maximum cycles in REQ before the access is aborted; range 1..255 (8-bit counter).

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_mem_re  input  1  load request from the decoder.
- i_mem_we  input  1  store request from the decoder.
- i_funct3  input  3  access width and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- i_addr  input  ADDR_WIDTH  byte address from the ALU.
- i_wdata  input  32  store data (rs2).
- o_rdata  output  32  extended load data, registered, valid in the DONE cycle.
- o_stall  output  1  core hold; the PC and register file must not advance while it is high.
- o_bus_err  output  1  one-cycle pulse on timeout abort.
- o_bus_valid  output  1  bus request.
- o_bus_we  output  1  1 = write.
- o_bus_addr  output  ADDR_WIDTH  word-aligned address: i_addr with bits [1:0] forced to 00.
- o_bus_wdata  output  32  lane-replicated store data.
- o_bus_wstrb  output  4  byte enables; 0000 on reads.
- i_bus_ready  input  1  bus accept/complete. Reads return data in the same cycle.
- i_bus_rdata  input  32  read data, sampled when valid and ready are both high.

Behaviour:
- Reset values (asynchronous, immediate):
  - state = IDLE.
  - o_bus_valid, o_bus_we, o_bus_err = 0.
  - o_rdata, o_bus_addr, o_bus_wdata = 0.
  - o_bus_wstrb = 0000.
  - Timeout counter = 0.
- FSM has three states: IDLE, REQ, DONE.
- IDLE:
  - o_stall = i_mem_re | i_mem_we (combinational), so it stalls in the same cycle the request appears.
  - On a request:
    - Latch addr, wstrb, wdata, we, funct3.
    - Clear the counter.
    - Go to REQ.
  - If both re and we are high, the store takes priority.
- REQ:
  - o_bus_valid = 1; all bus outputs stay stable until accepted; o_stall = 1.
  - On i_bus_ready:
    - For a load, register the extended data into o_rdata.
    - Go to DONE.
  - Without ready, the counter increments each cycle. When it reaches TIMEOUT_CYCLES-1 with no ready:
    - Drop valid.
    - Set o_rdata = 0.
    - Pulse o_bus_err.
    - Go to DONE.
  - If ready arrives in the same cycle the counter hits its limit, ready wins: normal completion, no error.
- DONE:
  - o_stall = 0 for exactly one cycle; the core writes back and advances at the end of this cycle.
  - Unconditionally return to IDLE; a new request is never accepted in DONE.
- Minimum latency (ready in the first REQ cycle): 2 stall cycles, so each access takes 3 cycles.
- Store lanes:
  - SB: wstrb = 0001 << addr[1:0]; wdata = {4{byte}}.
  - SH: wstrb = 0011 << {addr[1],1'b0}; wdata = {2{half}}.
  - SW: wstrb = 1111.
- Load extraction:
  - Select the byte lane by addr[1:0] and the half lane by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - An undefined funct3 is treated as W.
- Reset mid-transaction: immediate return to IDLE with o_bus_valid dropped; the in-flight bus response is ignored.
- Misaligned handling (SH/LH with addr[0]=1; W with addr[1:0]≠00) depends on the optional feature below.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned request in IDLE issues no bus transaction.
  - An output o_misaligned pulses for one cycle.
  - The FSM goes directly to DONE (1 stall cycle) with o_rdata = 0.
- Undefined:
  - Port o_misaligned is absent.
  - Low address bits beyond the access width are ignored, i.e. the access is forced-aligned.

Decomposition:
- parameters.vh gains:
  - FUNCT3_LB/LH/LW/LBU/LHU and FUNCT3_SB/SH/SW.
  - LSU state encodings LSU_IDLE=2'b00, LSU_REQ=2'b01, LSU_DONE=2'b10.
- One combinational sub-module, lsu_align: wstrb/wdata generation plus load extraction/extension, and misaligned detection.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, ready high on the first REQ cycle → one cycle with valid=1, we=1, wstrb=1111, addr=0x100; o_stall high for 2 cycles, low in cycle 3.
- SB addr=0x103, wdata=0x000000AB → wstrb=1000, wdata=0xABABABAB, addr=0x100.
- LB addr=0x102, rdata=0x00800000 → o_rdata=0xFFFFFF80. Then LBU with the same data → o_rdata=0x00000080. Then LHU addr=0x102, rdata=0xBEEF0000 → o_rdata=0x0000BEEF.
- LW with ready withheld 5 cycles → valid and addr held stable for 6 cycles, o_stall high for 7 cycles. With ready never asserted (TIMEOUT_CYCLES=8) → o_bus_err pulse, o_rdata=0, return to IDLE.
- i_rst asserted during REQ → o_bus_valid=0 immediately. A late ready after reset deasserts → o_rdata stays 0.
- LSU_MISALIGN_TRAP_EN defined: LW addr=0x101 → no valid, o_misaligned=1 for one cycle, stall for 1 cycle.
